// File: rtl/nic_queued.sv
// nic_queued: CPU <-> mesh-router network interface with DEPTH-deep FIFOs on
// both directions, VC-polarity-gated injection, and memory-mapped status.
// DEPTH must be a power of two >= 2; PACKET_WIDTH must be >= 16 so the status
// words fit; $clog2(DEPTH)+1 must be <= 8 so a count fits in bits [15:8].
module nic_queued #(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 4,
  parameter int VC_BIT       = 63
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              addr,
  input  logic [PACKET_WIDTH-1:0] d_in,
  output logic [PACKET_WIDTH-1:0] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  input  logic                    net_si,
  output logic                    net_ri,
  input  logic [PACKET_WIDTH-1:0] net_di,
  output logic                    net_so,
  input  logic                    net_ro,
  output logic [PACKET_WIDTH-1:0] net_do,
  input  logic                    net_polarity
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] ADDR_IN_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_OUT_DATA   = 2'd2;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'd3;

  // Router -> CPU FIFO
  logic [PACKET_WIDTH-1:0] in_mem [DEPTH];
  logic [PW-1:0]           in_rd_ptr, in_wr_ptr;
  logic [CW-1:0]           in_count;

  // CPU -> router FIFO
  logic [PACKET_WIDTH-1:0] out_mem [DEPTH];
  logic [PW-1:0]           out_rd_ptr, out_wr_ptr;
  logic [CW-1:0]           out_count;

  logic overflow;

  logic                    cpu_rd, cpu_wr;
  logic                    in_push, in_pop, in_empty;
  logic                    out_push, out_pop, out_full, out_empty;
  logic                    overflow_set, overflow_clr;
  logic [PACKET_WIDTH-1:0] in_head, out_head;

  assign cpu_rd    = nicEn && !nicEnWR;
  assign cpu_wr    = nicEn && nicEnWR;

  assign in_empty  = (in_count == '0);
  assign out_empty = (out_count == '0);
  assign out_full  = (out_count == FULL_COUNT);

  assign in_head   = in_mem[in_rd_ptr];
  assign out_head  = out_mem[out_rd_ptr];

  // Ready comes only from the registered count: a CPU pop this cycle does not
  // open a slot for the router until the next cycle.
  assign net_ri    = !reset && (in_count != FULL_COUNT);
  assign in_push   = net_si && net_ri;
  assign in_pop    = cpu_rd && (addr == ADDR_IN_DATA) && !in_empty;

  // A head whose VC tag disagrees with the router polarity stalls the queue.
  assign out_pop   = !out_empty && net_ro && (out_head[VC_BIT] == net_polarity);

  // A full queue that is injecting this cycle still frees a slot, so the write
  // is accepted; both decisions use start-of-cycle state only.
  assign out_push     = cpu_wr && (addr == ADDR_OUT_DATA) && (!out_full || out_pop);
  assign overflow_set = cpu_wr && (addr == ADDR_OUT_DATA) && out_full && !out_pop;
  assign overflow_clr = cpu_rd && (addr == ADDR_OUT_STATUS);

  // CPU read mux: data or status word for the selected register, else zero.
  always_comb begin
    // NOTE: defaulting every output first keeps this block free of inferred latches.
    d_out = '0;
    if (cpu_rd) begin
      case (addr)
        ADDR_IN_DATA: begin
          if (!in_empty) d_out = in_head;
        end
        ADDR_IN_STATUS: begin
          d_out[8 +: CW] = in_count;
          d_out[0]       = !in_empty;
        end
        ADDR_OUT_STATUS: begin
          d_out[8 +: CW] = out_count;
          d_out[1]       = overflow;
          d_out[0]       = out_full;
        end
        default: d_out = '0;
      endcase
    end
  end

  // Storage for both FIFOs; entries are only ever read behind a valid count.
  // NOTE: the data arrays carry no reset -- pointers and counts define validity,
  // so resetting the RAM would only cost area and routing.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr_ptr]   <= net_di;
    if (out_push) out_mem[out_wr_ptr] <= d_in;
  end

  // Input FIFO pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_rd_ptr <= '0;
      in_wr_ptr <= '0;
      in_count  <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + 1'b1;
        2'b01:   in_count <= in_count - 1'b1;
        default: in_count <= in_count;
      endcase
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_rd_ptr <= '0;
      out_wr_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: out_count <= out_count;
      endcase
    end
  end

  // Registered injection port: pulse net_so and hold the last packet on net_do.
  always_ff @(posedge clk) begin
    if (reset) begin
      net_so <= 1'b0;
      net_do <= '0;
    end else begin
      net_so <= out_pop;
      if (out_pop) net_do <= out_head;
    end
  end

  // Sticky overflow flag: a dropped write wins over a same-cycle status read.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (overflow_set) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nic_queued.sv
// tb_nic_queued: directed, table-driven bench for nic_queued plus a
// hand-written mid-operation reset sequence.
module tb_nic_queued;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   addr;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         nicEn;
  logic         nicEnWR;
  logic         net_si;
  logic         net_ri;
  logic [W-1:0] net_di;
  logic         net_so;
  logic         net_ro;
  logic [W-1:0] net_do;
  logic         net_polarity;

  int pass_count  = 0;
  int total_count = 0;

  always #5 clk = ~clk;

  nic_queued #(.PACKET_WIDTH(W), .DEPTH(4), .VC_BIT(63)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWR      (nicEnWR),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  typedef struct {
    logic         rst;
    logic         en;
    logic         wr;
    logic [1:0]   addr;
    logic [W-1:0] din;
    logic         si;
    logic [W-1:0] di;
    logic         ro;
    logic         pol;
    logic [W-1:0] exp_dout;  // combinational, sampled mid-cycle
    logic         exp_ri;    // combinational, sampled mid-cycle
    logic         exp_so;    // registered, sampled after the edge
    logic [W-1:0] exp_do;    // registered, sampled after the edge
  } vec_t;

  vec_t vecs[$];

  localparam logic [W-1:0] P1 = 64'h8000_0000_0000_0001;

  function automatic logic [W-1:0] qv(int i);  // VC=0 output packets
    return 64'h0000_0000_0000_00A0 + 64'(i);
  endfunction
  function automatic logic [W-1:0] rv(int i);  // VC=0 output packets
    return 64'h0000_0000_0000_0B00 + 64'(i);
  endfunction
  function automatic logic [W-1:0] av(int i);  // router-side packets
    return 64'h5A5A_0000_1234_0000 + 64'(i);
  endfunction
  function automatic logic [W-1:0] tv(int i);  // VC=1 packets for the reset test
    return 64'h8000_0000_0000_0C00 + 64'(i);
  endfunction

  function automatic vec_t mk(logic rst, logic en, logic wr, logic [1:0] a,
                              logic [W-1:0] din, logic si, logic [W-1:0] di,
                              logic ro, logic pol, logic [W-1:0] e_dout,
                              logic e_ri, logic e_so, logic [W-1:0] e_do);
    vec_t v;
    v.rst = rst; v.en = en; v.wr = wr; v.addr = a; v.din = din;
    v.si = si; v.di = di; v.ro = ro; v.pol = pol;
    v.exp_dout = e_dout; v.exp_ri = e_ri; v.exp_so = e_so; v.exp_do = e_do;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] actual,
                       input logic [W-1:0] expected);
    total_count++;
    if (actual === expected) pass_count++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic drive(input logic rst, input logic en, input logic wr,
                       input logic [1:0] a, input logic [W-1:0] din,
                       input logic si, input logic [W-1:0] di,
                       input logic ro, input logic pol);
    reset = rst; nicEn = en; nicEnWR = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    drive(v.rst, v.en, v.wr, v.addr, v.din, v.si, v.di, v.ro, v.pol);
    #4;
    check($sformatf("v%0d d_out", idx), d_out, v.exp_dout);
    check($sformatf("v%0d net_ri", idx), W'(net_ri), W'(v.exp_ri));
    tick();
    check($sformatf("v%0d net_so", idx), W'(net_so), W'(v.exp_so));
    check($sformatf("v%0d net_do", idx), net_do, v.exp_do);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset, then idle status reads.
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,1,0,1,0,0,0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,1,0,3,0,0,0,0,0, 0,1,0,0));
    // VC=1 packet waits for polarity 1, injects once.
    vecs.push_back(mk(0,1,1,2,P1,0,0,1,0, 0,1,0,0));
    vecs.push_back(mk(0,1,0,3,0,0,0,1,0, 64'h100,1,0,0));
    vecs.push_back(mk(0,1,0,3,0,0,0,1,1, 64'h100,1,1,P1));
    vecs.push_back(mk(0,1,0,3,0,0,0,1,0, 0,1,0,P1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,1, 0,1,0,P1));
    // Five writes into a 4-deep queue with the router stalled.
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,1,1,2,qv(i),0,0,0,0, 0,1,0,P1));
    vecs.push_back(mk(0,1,0,3,0,0,0,0,0, 64'h403,1,0,P1));
    vecs.push_back(mk(0,1,0,3,0,0,0,0,0, 64'h401,1,0,P1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,0,0,0,1,0, 0,1,1,qv(i)));
    vecs.push_back(mk(0,1,0,3,0,0,0,1,0, 0,1,0,qv(3)));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,1, 0,1,0,qv(3)));
    // Router fills the input FIFO; fifth offer is refused.
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,0,1,av(i),0,0, 0,1,0,qv(3)));
    vecs.push_back(mk(0,1,0,1,0,1,av(4),0,0, 64'h401,0,0,qv(3)));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,0,0,0,0,0,0,0, av(i),(i == 0) ? 1'b0 : 1'b1,0,qv(3)));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 0,1,0,qv(3)));
    vecs.push_back(mk(0,1,0,1,0,0,0,0,0, 0,1,0,qv(3)));
    // Simultaneous router push and CPU pop at in_count=2.
    vecs.push_back(mk(0,0,0,0,0,1,av(10),0,0, 0,1,0,qv(3)));
    vecs.push_back(mk(0,0,0,0,0,1,av(11),0,0, 0,1,0,qv(3)));
    vecs.push_back(mk(0,1,0,0,0,1,av(12),0,0, av(10),1,0,qv(3)));
    vecs.push_back(mk(0,1,0,1,0,0,0,0,0, 64'h201,1,0,qv(3)));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, av(11),1,0,qv(3)));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, av(12),1,0,qv(3)));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 0,1,0,qv(3)));
    // Output full: injection pop plus CPU write in the same cycle.
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,1,1,2,rv(i),0,0,0,0, 0,1,0,qv(3)));
    vecs.push_back(mk(0,1,1,2,rv(4),0,0,1,0, 0,1,1,rv(0)));
    vecs.push_back(mk(0,1,0,3,0,0,0,0,0, 64'h401,1,0,rv(0)));
    for (int i = 1; i < 5; i++) vecs.push_back(mk(0,0,0,0,0,0,0,1,0, 0,1,1,rv(i)));
    vecs.push_back(mk(0,1,0,3,0,0,0,1,0, 0,1,0,rv(4)));
    // Writes to non-output registers are ignored; addr 2 reads as zero.
    vecs.push_back(mk(0,1,1,0,64'hDEAD,0,0,0,0, 0,1,0,rv(4)));
    vecs.push_back(mk(0,1,1,3,64'hBEEF,0,0,0,0, 0,1,0,rv(4)));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 0,1,0,rv(4)));
    vecs.push_back(mk(0,1,0,2,0,0,0,0,0, 0,1,0,rv(4)));
    vecs.push_back(mk(0,1,0,3,0,0,0,0,0, 0,1,0,rv(4)));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Mid-operation reset with three packets queued in each direction.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 2'd2, tv(k), 1, av(20 + k), 0, 0);
      tick();
    end
    drive(0, 1, 0, 2'd1, 0, 0, 0, 0, 0);
    #4 check("pre-reset in status", d_out, 64'h301);
    tick();
    drive(0, 1, 0, 2'd3, 0, 0, 0, 0, 0);
    #4 check("pre-reset out status", d_out, 64'h300);
    tick();
    drive(1, 0, 0, 2'd0, 0, 0, 0, 1, 1);
    #4 check("reset net_ri", W'(net_ri), 0);
    tick();
    check("reset net_so", W'(net_so), 0);
    check("reset net_do", net_do, 0);
    drive(0, 1, 0, 2'd1, 0, 0, 0, 1, 1);
    #4 check("post-reset in status", d_out, 0);
    check("post-reset net_ri", W'(net_ri), 1);
    tick();
    drive(0, 1, 0, 2'd3, 0, 0, 0, 1, 0);
    #4 check("post-reset out status", d_out, 0);
    tick();
    drive(0, 1, 0, 2'd0, 0, 0, 0, 1, 1);
    #4 check("post-reset in data", d_out, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 2'd0, 0, 0, 0, 1, k[0]);
      tick();
      check($sformatf("post-reset no stale so %0d", k), W'(net_so), 0);
      check($sformatf("post-reset no stale do %0d", k), net_do, 0);
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/nic_queued.md
Name: nic_queued

Overview:
- Next-generation network interface between a four_stage_processor and its mesh router.
- Replaces the single-entry channel buffers with parametrised DEPTH-deep FIFOs on both the CPU→router (output) and router→CPU (input) paths.
- Injects only on the router's matching virtual-channel polarity.
- Exposes occupancy and a sticky overflow flag to software through memory-mapped status words.

Parameters:
- PACKET_WIDTH, 64, packet/data word width.
- DEPTH, 4, entries per FIFO; power of two, ≥2.
- VC_BIT, 63, packet bit index holding the virtual-channel tag.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high, single clock domain.
- addr  in  2  CPU register select: 0 = input data, 1 = input status, 2 = output data, 3 = output status.
- d_in  in  PACKET_WIDTH  CPU write data.
- d_out  out  PACKET_WIDTH  CPU read data.
- nicEn  in  1  CPU access enable.
- nicEnWR  in  1  1 = write, 0 = read (valid only with nicEn).
- net_si  in  1  router send-in (packet valid on net_di).
- net_ri  out  1  NIC ready to accept from router.
- net_di  in  PACKET_WIDTH  packet from router.
- net_so  out  1  NIC send-out to router.
- net_ro  in  1  router ready to accept.
- net_do  out  PACKET_WIDTH  packet to router.
- net_polarity  in  1  router's current cycle polarity.

Behaviour:
- Reset, synchronous:
  - Both FIFOs empty; pointers and counts 0.
  - net_so=0, net_do=0, overflow flag=0.
  - net_ri=0 while reset is high.
- Counts are $clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.
- Input path (router→NIC):
  - net_ri = !reset && (in_count != DEPTH). It is combinational from registered count, with no same-cycle pop bypass.
  - On an edge with net_si && net_ri: push net_di.
- CPU read (nicEn && !nicEnWR), d_out combinational:
  - addr 0: d_out = input head if non-empty, else 0. On the edge, pop if non-empty. Reading when empty has no effect.
  - addr 1: d_out = {in_count zero-extended into bits [15:8], bit0 = (in_count != 0)}, other bits 0.
  - addr 3: d_out = {out_count in bits [15:8], bit1 = overflow, bit0 = (out_count == DEPTH)}. The read clears overflow on the edge.
  - addr 2: d_out = 0.
  - When nicEn=0 or nicEnWR=1: d_out = 0.
- CPU write (nicEn && nicEnWR):
  - addr 2: push d_in if out_count != DEPTH at cycle start. Otherwise the word is dropped and overflow is set. Set takes priority over a same-cycle clear.
  - Writes to addr 0/1/3 are ignored.
- Injection (registered):
  - Each edge: if out_count != 0 && net_ro && head[VC_BIT] == net_polarity, then net_so<=1, net_do<=head, and pop.
  - Otherwise net_so<=0 and net_do holds its last value.
  - At most one injection per cycle. A non-matching head blocks the queue; no reordering.
- Simultaneous push and pop on the same FIFO: both occur and the count is unchanged. This is legal at any occupancy, including full-with-pop for the output FIFO, because the push condition is evaluated against the start-of-cycle count.
- Reset mid-operation: all queued packets are discarded and the next cycle behaves as after reset.
- Latency:
  - CPU write to net_so: at least 2 edges (push, then inject).
  - Router push to CPU-visible data: 1 edge.

Test Plan:
- Reset then idle → net_so=0, net_ri=1 after reset is released; status reads return 0.
- Write 0x8000_0000_0000_0001 (VC=1) at addr 2, net_ro=1, polarity toggling from 0 → net_so pulses one cycle, on the first edge where polarity=1, with net_do equal to the packet; out_count returns to 0.
- Write 5 packets with DEPTH=4 and net_ro=0 → addr 3 reads bit0=1, bit1=1, count=4; a second addr-3 read shows bit1=0; the 5th packet is never injected.
- Router pushes 4 packets A–D, net_si held → net_ri drops after D; CPU addr-0 reads return A, B, C, D in order, then 0; addr 1 bit0 goes 1→0.
- Same cycle: CPU pops input while router pushes at in_count=2 → count stays 2 and FIFO order is preserved; repeat on the output side at full with an injection pop plus CPU write → write accepted, no overflow.
- Assert reset for one cycle with 3 queued packets in each FIFO → both counts 0, net_so=0, and no stale packet is ever emitted.
